obi_demux: RTL and testbench



---
 rtl/obi_demux.sv | 178 +++++++++++++++++
 tb/tb_obi_demux.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_demux.sv
`default_nettype none
// obi_demux: routes one OBI manager to NumMstPorts subordinates, keeping responses in order. Rev 1.0
// Define OBI_DEMUX_ERR_RESP_EN to answer out-of-range selects from an internal error responder.

package obi_pkg;

  typedef struct packed {
    logic        UseRReady;
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0,
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   4
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_demux #(
  parameter obi_pkg::obi_cfg_t SlvPortObiCfg = obi_pkg::ObiDefaultConfig,
  parameter obi_pkg::obi_cfg_t MstPortObiCfg = SlvPortObiCfg,
  parameter type               obi_req_t     = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t     = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumMstPorts   = 2,
  parameter int unsigned       NumMaxTrans   = 2,
  parameter int unsigned       SelWidth      = $clog2(NumMstPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  obi_req_t            slv_port_obi_req_i,
  output obi_rsp_t            slv_port_obi_rsp_o,
  input  logic [SelWidth-1:0] slv_port_select_i,
  output obi_req_t            mst_ports_obi_req_o [NumMstPorts],
  input  obi_rsp_t            mst_ports_obi_rsp_i [NumMstPorts]
);

  localparam int unsigned CntWidth  = $clog2(NumMaxTrans + 1);
  localparam logic        UseRReady = SlvPortObiCfg.UseRReady | MstPortObiCfg.UseRReady;
`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam int unsigned TgtWidth  = SelWidth + 1;
`else
  localparam int unsigned TgtWidth  = SelWidth;
`endif
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumMaxTrans);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TgtWidth-1:0] sel_q, tgt;
  logic                sel_in_range, tgt_valid, tgt_gnt;
  logic                allow, gnt, accept, retire;
  obi_rsp_t            sel_rsp;

  assign sel_in_range = (32'(slv_port_select_i) < NumMstPorts);

`ifdef OBI_DEMUX_ERR_RESP_EN
  // Out-of-range selects map onto the virtual port index NumMstPorts.
  logic     tgt_is_err, sel_is_err;
  obi_rsp_t err_rsp_q;

  assign tgt        = sel_in_range ? TgtWidth'(slv_port_select_i) : TgtWidth'(NumMstPorts);
  assign tgt_valid  = 1'b1;
  assign tgt_is_err = (tgt == TgtWidth'(NumMstPorts));
  assign sel_is_err = (sel_q == TgtWidth'(NumMstPorts));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_rsp_q <= '0;
    end else if (accept && tgt_is_err) begin
      err_rsp_q.gnt     <= 1'b0;
      err_rsp_q.rvalid  <= 1'b1;
      err_rsp_q.r.rdata <= '0;
      err_rsp_q.r.rid   <= slv_port_obi_req_i.a.aid;
      err_rsp_q.r.err   <= 1'b1;
    end else if (retire && sel_is_err) begin
      err_rsp_q.rvalid  <= 1'b0;
    end
  end
`else
  assign tgt       = slv_port_select_i;
  assign tgt_valid = sel_in_range;
`endif

  // Reset gates the request path so nothing leaks out while rst_ni is low.
  assign allow = rst_ni && tgt_valid
              && ((cnt_q == '0) || (tgt == sel_q))
              && (cnt_q != CntMax);

  always_comb begin
    tgt_gnt = 1'b0;
    for (int unsigned i = 0; i < NumMstPorts; i++) begin
      if (tgt == TgtWidth'(i)) tgt_gnt = mst_ports_obi_rsp_i[i].gnt;
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    // The responder holds a single transaction at a time.
    if (tgt_is_err) tgt_gnt = !err_rsp_q.rvalid;
`endif
  end

  assign gnt    = allow && tgt_gnt;
  assign accept = slv_port_obi_req_i.req && gnt;

  always_comb begin
    for (int unsigned i = 0; i < NumMstPorts; i++) begin
      mst_ports_obi_req_o[i]        = slv_port_obi_req_i;
      mst_ports_obi_req_o[i].req    = slv_port_obi_req_i.req && allow && (tgt == TgtWidth'(i));
      mst_ports_obi_req_o[i].rready = slv_port_obi_req_i.rready && (sel_q == TgtWidth'(i));
    end
  end

  always_comb begin
    sel_rsp = '0;
    for (int unsigned i = 0; i < NumMstPorts; i++) begin
      if (sel_q == TgtWidth'(i)) sel_rsp = mst_ports_obi_rsp_i[i];
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    if (sel_is_err) sel_rsp = err_rsp_q;
`endif
  end

  always_comb begin
    slv_port_obi_rsp_o     = sel_rsp;
    slv_port_obi_rsp_o.gnt = gnt;
  end

  assign retire = sel_rsp.rvalid && (UseRReady ? slv_port_obi_req_i.rready : 1'b1);

  // A stray retire with nothing outstanding must not wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (retire && !accept && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) sel_q <= tgt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_demux.sv
`default_nettype none
// tb_obi_demux: directed stimulus for obi_demux, checked every cycle against a queue-based model.
module tb_obi_demux;
  import obi_pkg::*;

  localparam int NP = 3;
  localparam int NT = 2;
  localparam int SW = 2;
  localparam obi_cfg_t Cfg = '{UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32, IdWidth: 4};
`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  obi_req_t      slv_req;
  obi_rsp_t      slv_rsp;
  logic [SW-1:0] sel;
  obi_req_t      mst_req [NP];
  obi_rsp_t      mst_rsp [NP];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO of outstanding targets, last-locked target, error id.
  int       q[$];
  int       lock = 0;
  logic [3:0] err_id = '0;
  bit       mvalid = 1'b0;

  always #5 clk = ~clk;

  obi_demux #(
    .SlvPortObiCfg(Cfg),
    .MstPortObiCfg(Cfg),
    .obi_req_t    (obi_req_t),
    .obi_rsp_t    (obi_rsp_t),
    .NumMstPorts  (NP),
    .NumMaxTrans  (NT),
    .SelWidth     (SW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .slv_port_obi_req_i (slv_req),
    .slv_port_obi_rsp_o (slv_rsp),
    .slv_port_select_i  (sel),
    .mst_ports_obi_req_o(mst_req),
    .mst_ports_obi_rsp_i(mst_rsp)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int tgt_of(logic [SW-1:0] s);
    if (int'(s) < NP) return int'(s);
    return ErrEn ? NP : -1;
  endfunction

  function automatic bit exp_allow();
    int t = tgt_of(sel);
    return rst_ni && (t >= 0) && (q.size() == 0 || t == lock) && (q.size() < NT);
  endfunction

  function automatic bit exp_gnt();
    int t = tgt_of(sel);
    if (!exp_allow()) return 1'b0;
    if (t == NP) return !(lock == NP && q.size() > 0);
    return mst_rsp[t].gnt;
  endfunction

  function automatic obi_rsp_t exp_rsp();
    obi_rsp_t r = '0;
    if (lock < NP) begin
      r = mst_rsp[lock];
    end else begin
      r.rvalid = (q.size() > 0);
      r.r.err  = 1'b1;
      r.r.rid  = err_id;
    end
    r.gnt = exp_gnt();
    return r;
  endfunction

  function automatic obi_req_t exp_mreq(int i);
    obi_req_t m = slv_req;
    m.req    = slv_req.req && exp_allow() && (tgt_of(sel) == i);
    m.rready = slv_req.rready && (lock == i);
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      q.delete();
      lock   = 0;
      err_id = '0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      obi_rsp_t r;
      bit acc, ret;
      int t;
      r   = exp_rsp();
      t   = tgt_of(sel);
      ret = r.rvalid && slv_req.rready;
      acc = slv_req.req && r.gnt;
      if (ret && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(t);
        lock = t;
        if (t == NP) err_id = slv_req.a.aid;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("cmp_slv_rsp", slv_rsp, exp_rsp());
      for (int i = 0; i < NP; i++) check($sformatf("cmp_mst_req%0d", i), mst_req[i], exp_mreq(i));
      check("cmp_cnt", dut.cnt_q, q.size());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slv_req        = '0;
    slv_req.rready = 1'b1;
    slv_req.a.addr = 32'h0000_1000;
    slv_req.a.be   = 4'hF;
    sel            = '0;
    for (int i = 0; i < NP; i++) begin
      mst_rsp[i]     = '0;
      mst_rsp[i].gnt = 1'b1;
    end
  endtask

  initial begin
    idle();
    slv_req.req = 1'b1;
    sel         = 2'd1;
    rst_ni      = 1'b0;
    cyc();
    #2;
    check("rst_gnt", slv_rsp.gnt, 0);
    check("rst_p1_req", mst_req[1].req, 0);
    cyc();
    rst_ni = 1'b1;
    #2;
    check("post_rst_p1_req", mst_req[1].req, 1);
    check("post_rst_cnt", dut.cnt_q, 0);

    cyc();
    slv_req.req         = 1'b0;
    mst_rsp[1].rvalid   = 1'b1;
    mst_rsp[1].r.rdata  = 32'h1111_0000;
    #2;
    check("p1_rdata", slv_rsp.r.rdata, 32'h1111_0000);
    check("p1_cnt", dut.cnt_q, 1);

    // Two back-to-back accepts to port 0 fill the counter.
    cyc();
    idle();
    slv_req.req    = 1'b1;
    sel            = 2'd0;
    slv_req.a.addr = 32'h0000_0100;
    cyc();
    cyc();
    #2;
    check("full_cnt", dut.cnt_q, 2);
    check("full_gnt", slv_rsp.gnt, 0);
    check("full_p0_req", mst_req[0].req, 0);
    cyc();
    mst_rsp[0].rvalid = 1'b1;
    #2;
    check("full_retire_gnt", slv_rsp.gnt, 0);
    cyc();
    mst_rsp[0].rvalid = 1'b0;
    #2;
    check("third_cnt", dut.cnt_q, 1);
    check("third_gnt", slv_rsp.gnt, 1);
    cyc();
    slv_req.req       = 1'b0;
    mst_rsp[0].rvalid = 1'b1;
    cyc();
    cyc();
    mst_rsp[0].rvalid = 1'b0;
    #2;
    check("drain_cnt", dut.cnt_q, 0);

    // Target switch stalls until port 0 has retired.
    cyc();
    slv_req.req = 1'b1;
    sel         = 2'd0;
    cyc();
    sel = 2'd1;
    #2;
    check("sw_p1_req", mst_req[1].req, 0);
    check("sw_gnt", slv_rsp.gnt, 0);
    cyc();
    #2;
    check("sw_p1_req_hold", mst_req[1].req, 0);
    cyc();
    mst_rsp[0].rvalid = 1'b1;
    #2;
    check("sw_gnt_retire", slv_rsp.gnt, 0);
    cyc();
    mst_rsp[0].rvalid = 1'b0;
    #2;
    check("sw_p1_req_go", mst_req[1].req, 1);
    check("sw_gnt_go", slv_rsp.gnt, 1);
    cyc();
    slv_req.req       = 1'b0;
    mst_rsp[1].rvalid = 1'b1;
    #2;
    check("sw_sel_q", dut.sel_q, 1);
    check("sw_cnt", dut.cnt_q, 1);
    cyc();
    mst_rsp[1].rvalid = 1'b0;

    // Subordinate gnt gating, then accept and retire in the same cycle.
    cyc();
    slv_req.req    = 1'b1;
    sel            = 2'd0;
    mst_rsp[0].gnt = 1'b0;
    #2;
    check("nogrant_gnt", slv_rsp.gnt, 0);
    check("nogrant_p0_req", mst_req[0].req, 1);
    cyc();
    mst_rsp[0].gnt = 1'b1;
    cyc();
    mst_rsp[0].rvalid  = 1'b1;
    mst_rsp[0].r.rdata = 32'hA5A5_0001;
    #2;
    check("ar_rvalid", slv_rsp.rvalid, 1);
    check("ar_rdata", slv_rsp.r.rdata, 32'hA5A5_0001);
    check("ar_gnt", slv_rsp.gnt, 1);
    cyc();
    slv_req.req       = 1'b0;
    mst_rsp[0].rvalid = 1'b0;
    #2;
    check("ar_cnt", dut.cnt_q, 1);
    cyc();
    mst_rsp[0].rvalid = 1'b1;
    cyc();
    mst_rsp[0].rvalid = 1'b0;

    // Back-pressure through rready.
    cyc();
    slv_req.req = 1'b1;
    sel         = 2'd1;
    cyc();
    slv_req.req       = 1'b0;
    slv_req.rready    = 1'b0;
    mst_rsp[1].rvalid = 1'b1;
    mst_rsp[1].r.rdata = 32'h0000_BEEF;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("rr_cnt", dut.cnt_q, 1);
      check("rr_p1_rready", mst_req[1].rready, 0);
      check("rr_p0_rready", mst_req[0].rready, 0);
      cyc();
    end
    slv_req.rready = 1'b1;
    #2;
    check("rr_p1_rready_go", mst_req[1].rready, 1);
    cyc();
    mst_rsp[1].rvalid = 1'b0;
    #2;
    check("rr_cnt_done", dut.cnt_q, 0);

    // Out-of-range select.
    cyc();
    slv_req.req   = 1'b1;
    sel           = 2'd3;
    slv_req.a.aid = 4'h9;
`ifdef OBI_DEMUX_ERR_RESP_EN
    #2;
    check("err_gnt", slv_rsp.gnt, 1);
    cyc();
    slv_req.rready = 1'b0;
    #2;
    check("err_rvalid", slv_rsp.rvalid, 1);
    check("err_err", slv_rsp.r.err, 1);
    check("err_rdata", slv_rsp.r.rdata, 0);
    check("err_rid", slv_rsp.r.rid, 4'h9);
    check("err_busy_gnt", slv_rsp.gnt, 0);
    cyc();
    slv_req.req    = 1'b0;
    slv_req.rready = 1'b1;
    cyc();
    #2;
    check("err_cnt_done", dut.cnt_q, 0);
`else
    for (int k = 0; k < 20; k++) begin
      #2;
      check("oor_gnt", slv_rsp.gnt, 0);
      cyc();
    end
    slv_req.req = 1'b0;
`endif

    cyc();
    idle();
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
